// File: rtl/stereo_pwm_audio_pkg.sv
// Shared constants and types for the stereo PWM audio output stage.
// Optional build macro SDM_EN switches both channels to delta-sigma.
package stereo_pwm_audio_pkg;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 2;   // lane 0 = left, lane 1 = right
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef logic [WIDTH-1:0] duty_t;
endpackage

// File: rtl/stereo_pwm_audio_if.sv
// Duty inputs and PWM outputs of the stereo PWM audio stage.
//   left_top/right_top : duty per channel (sampled at period start)
//   left/right         : registered 1-bit PWM streams
// master = sample source side, slave = the PWM stage.
interface stereo_pwm_audio_if import stereo_pwm_audio_pkg::*; ;
  duty_t left_top;
  duty_t right_top;
  logic  left;
  logic  right;

  modport master (output left_top, right_top, input left, right);
  modport slave  (input left_top, right_top, output left, right);
endinterface

// File: rtl/stereo_pwm_audio_pwm_channel.sv
// One PWM audio lane: duty latch plus comparator against the shared counter,
// or a first-order delta-sigma modulator when SDM_EN is defined.
//   clk, aclr : clock, async active-low clear
//   load      : period-start strobe (pre-edge counter == 0)
//   cnt_next  : shared counter value after this edge
//   top       : requested duty
//   pwm       : registered 1-bit output
module pwm_channel import stereo_pwm_audio_pkg::*; (
  input  logic  clk,
  input  logic  aclr,
  input  logic  load,
  input  duty_t cnt_next,
  input  duty_t top,
  output logic  pwm
);
  duty_t duty_q;
  duty_t duty_nxt;

  // Duty only changes on the period-start edge, so mid-period writes never glitch.
  assign duty_nxt = load ? top : duty_q;

  always_ff @(posedge clk or negedge aclr)
    if (!aclr) duty_q <= '0;
    else       duty_q <= duty_nxt;

`ifdef SDM_EN
  logic [WIDTH:0] acc;
  logic [WIDTH:0] acc_nxt;
  logic           unused_cnt;

  assign unused_cnt = ^cnt_next;
  // Carry out of the running sum is the bitstream; the low bits keep the residue.
  assign acc_nxt    = {1'b0, acc[WIDTH-1:0]} + {1'b0, duty_nxt};

  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      acc <= acc_nxt;
      pwm <= acc_nxt[WIDTH];
    end
`else
  // Compare next-state values so the flop holds exactly (cnt < duty_q) post-edge.
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) pwm <= 1'b0;
    else       pwm <= (cnt_next < duty_nxt);
`endif
endmodule

// File: rtl/stereo_pwm_audio.sv
// Stereo PWM audio DAC output stage: one free-running counter shared by the
// left and right channels. Period is 2^WIDTH clocks; duties latch when the
// counter leaves 0. Build with SDM_EN for delta-sigma channels.
//   clk  : audio clock
//   aclr : async active-low clear
//   bus  : duty inputs and PWM outputs (slave modport)
module stereo_pwm_audio import stereo_pwm_audio_pkg::*; (
  input logic               clk,
  input logic               aclr,
  stereo_pwm_audio_if.slave bus
);
  duty_t                cnt;
  duty_t                cnt_next;
  logic                 load;
  duty_t [NUM_CH-1:0]   top;
  logic  [NUM_CH-1:0]   pwm;

  assign cnt_next = duty_t'(cnt + 1'b1);   // MAX wraps to 0
  assign load     = (cnt == '0);

  always_ff @(posedge clk or negedge aclr)
    if (!aclr) cnt <= '0;
    else       cnt <= cnt_next;

  assign top       = {bus.right_top, bus.left_top};
  assign bus.left  = pwm[0];
  assign bus.right = pwm[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk      (clk),
      .aclr     (aclr),
      .load     (load),
      .cnt_next (cnt_next),
      .top      (top[g]),
      .pwm      (pwm[g])
    );
  end
endmodule

// File: tb/tb_stereo_pwm_audio.sv
// Self-checking bench for stereo_pwm_audio: per-period high counts and run
// shape from a duty table via a scoreboard, plus reset, mid-period change,
// counter wrap / load timing and async clear sequences.
module tb_stereo_pwm_audio;
  import stereo_pwm_audio_pkg::*;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  stereo_pwm_audio_if bus ();

  stereo_pwm_audio dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  typedef struct {
    duty_t l;
    duty_t r;
    int    exp_l;
    int    exp_r;
  } vec_t;

  typedef struct {
    string name;
    int    exp_l;
    int    exp_r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   lh, rh, ltr, rtr;   // highs and rising edges (circular) in one period

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Runs 256 edges starting with pre-edge cnt==0; optionally rewrites
  // left_top while the pre-edge counter equals chg_at.
  task automatic run_period(input int chg_at, input duty_t chg_val);
    logic pl, pr, fl, fr;
    lh = 0; rh = 0; ltr = 0; rtr = 0;
    pl = 1'b0; pr = 1'b0; fl = 1'b0; fr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == chg_at) bus.left_top = chg_val;
      @(posedge clk); #1;
      lh += int'(bus.left);
      rh += int'(bus.right);
      if (i == 0) begin
        fl = bus.left; fr = bus.right;
      end else begin
        if (bus.left  && !pl) ltr++;
        if (bus.right && !pr) rtr++;
      end
      pl = bus.left; pr = bus.right;
    end
    if (fl && !pl) ltr++;
    if (fr && !pr) rtr++;
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_left_highs"},  lh, e.exp_l);
      chk({e.name, "_right_highs"}, rh, e.exp_r);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{l: 8'd0,   r: 8'd255, exp_l: 0,   exp_r: 255};
    vecs[1] = '{l: 8'd0,   r: 8'd255, exp_l: 0,   exp_r: 255};
    vecs[2] = '{l: 8'd64,  r: 8'd192, exp_l: 64,  exp_r: 192};
    vecs[3] = '{l: 8'd128, r: 8'd128, exp_l: 128, exp_r: 128};
    vecs[4] = '{l: 8'd1,   r: 8'd254, exp_l: 1,   exp_r: 254};
    vecs[5] = '{l: 8'd200, r: 8'd200, exp_l: 200, exp_r: 200};

    // Reset held with non-zero duty requested
    aclr = 1'b0;
    bus.left_top  = 8'h80;
    bus.right_top = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_left",  int'(bus.left),  0);
    chk("reset_right", int'(bus.right), 0);
    chk("reset_cnt",   int'(dut.cnt),   0);
    aclr = 1'b1;

    // Table: one full period per vector, first edge after release is a load edge
    foreach (vecs[k]) begin
      bus.left_top  = vecs[k].l;
      bus.right_top = vecs[k].r;
      sb.push_back('{name: $sformatf("vec%0d", k), exp_l: vecs[k].exp_l, exp_r: vecs[k].exp_r});
      run_period(-1, 8'd0);
      pop_chk();
`ifdef SDM_EN
      if (vecs[k].l == 8'd128) chk($sformatf("vec%0d_left_toggles", k), ltr, 128);
      if (vecs[k].r == 8'd128) chk($sformatf("vec%0d_right_toggles", k), rtr, 128);
`else
      chk($sformatf("vec%0d_left_runs", k),  ltr, (vecs[k].l != 0) ? 1 : 0);
      chk($sformatf("vec%0d_right_runs", k), rtr, (vecs[k].r != 0) ? 1 : 0);
`endif
    end

    // Mid-period change: 32 -> 200 while cnt==100 only lands next period
    bus.left_top  = 8'd32;
    bus.right_top = 8'd0;
    sb.push_back('{name: "midchg_cur", exp_l: 32, exp_r: 0});
    run_period(100, 8'd200);
    pop_chk();
    sb.push_back('{name: "midchg_next", exp_l: 200, exp_r: 0});
    run_period(-1, 8'd0);
    pop_chk();

    // Latch a duty of 0 so an early load would be visible in the cnt==0 slot
    bus.left_top = 8'd0;
    sb.push_back('{name: "zero", exp_l: 0, exp_r: 0});
    run_period(-1, 8'd0);
    pop_chk();

    // Wrap 254,255,0,1 with the new duty presented before the wrap
    repeat (254) @(posedge clk);
    #1;
    chk("wrap_cnt254", int'(dut.cnt), 254);
    bus.left_top = 8'd100;
    @(posedge clk); #1;
    chk("wrap_cnt255", int'(dut.cnt), 255);
`ifndef SDM_EN
    chk("wrap_left_at255", int'(bus.left), 0);
`endif
    @(posedge clk); #1;
    chk("wrap_cnt0", int'(dut.cnt), 0);
`ifndef SDM_EN
    chk("wrap_no_early_load", int'(bus.left), 0);
`endif
    @(posedge clk); #1;
    chk("wrap_cnt1", int'(dut.cnt), 1);
`ifndef SDM_EN
    chk("wrap_load_on_leave0", int'(bus.left), 1);
`endif

    // Async clear mid-period drops outputs without a clock edge
    repeat (5) @(posedge clk);
    #1;
`ifndef SDM_EN
    chk("async_pre_left_high", int'(bus.left), 1);
`endif
    #2;
    aclr = 1'b0;
    #1;
    chk("async_left",  int'(bus.left),  0);
    chk("async_right", int'(bus.right), 0);
    chk("async_cnt",   int'(dut.cnt),   0);
    @(posedge clk); #1;
    aclr = 1'b1;

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
